// File: rtl/uart_pkg.sv
// Shared types and constants for the UART baud divisor controller.
package uart_pkg;

  localparam int unsigned T8_W  = 24;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned NE_W  = 3;

  localparam logic [T8_W-1:0] MAX_T8   = 24'h7FFFC0;
  localparam logic [T8_W-1:0] T8_ROUND = 24'd64;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HIGH,
    WAIT_FALL,
    MEASURE,
    CALC,
    COMMIT
  } ab_state_e;

  // T8 spans 8 bit times; divisor = bit_time / 16, rounded.
  function automatic logic [T8_W-1:0] t8_to_div(input logic [T8_W-1:0] t8);
    return (t8 + T8_ROUND) >> 7;
  endfunction

endpackage

// File: rtl/baud_rx_sync.sv
// RX line synchronizer (reset to idle-high) with a registered falling-edge strobe.
module baud_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_q;
  logic                   r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_rx_q <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_rx_q <= r_sync[SYNC_STAGES-1];
      r_fall <= r_rx_q & ~r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rx_s = r_sync[SYNC_STAGES-1];
  assign o_fall = r_fall;

endmodule

// File: rtl/baud_ctrl.sv
// Owns the 16x baud divisor: stages manual writes and auto-baud results and
// applies them only on a generator tick so the counter never overruns.
module baud_ctrl
  import uart_pkg::*;
#(
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd27,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [T8_W-1:0]  TIMEOUT_T8  = MAX_T8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_i,
  input  logic             en_16x_baud_i,
  input  logic             cfg_wr_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             ab_start_i,
  output logic [DIV_W-1:0] baud_config_o,
  output logic             cfg_pending_o,
  output logic             ab_busy_o,
  output logic             ab_done_o,
  output logic             ab_err_o
);

  logic w_rx_s;
  logic w_fall;

  baud_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clk   (clk),
    .rst   (rst),
    .i_rx  (rx_i),
    .o_rx_s(w_rx_s),
    .o_fall(w_fall)
  );

  ab_state_e        r_state, w_state_nxt;
  logic [T8_W-1:0]  r_t8, w_t8_nxt;
  logic [NE_W-1:0]  r_ne, w_ne_nxt;
  logic [DIV_W-1:0] r_pend, w_pend_nxt;
  logic             r_pending, w_pending_nxt;
  logic [DIV_W-1:0] r_baud, w_baud_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;

  logic [T8_W-1:0]  w_t8_inc;
  logic [T8_W-1:0]  w_ab_div;

  assign w_t8_inc = r_t8 + 24'd1;
  assign w_ab_div = t8_to_div(r_t8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_t8      <= '0;
      r_ne      <= '0;
      r_pend    <= '0;
      r_pending <= 1'b0;
      r_baud    <= DEFAULT_DIV;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_t8      <= w_t8_nxt;
      r_ne      <= w_ne_nxt;
      r_pend    <= w_pend_nxt;
      r_pending <= w_pending_nxt;
      r_baud    <= w_baud_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_t8_nxt      = r_t8;
    w_ne_nxt      = r_ne;
    w_pend_nxt    = r_pend;
    w_pending_nxt = r_pending;
    w_baud_nxt    = r_baud;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    // Commit the staged value first; a same-cycle load below re-arms the flag.
    if (en_16x_baud_i && r_pending) begin
      w_baud_nxt    = r_pend;
      w_pending_nxt = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (ab_start_i) begin
          w_state_nxt = WAIT_HIGH;
          w_busy_nxt  = 1'b1;
        end else if (cfg_wr_i) begin
          if (cfg_div_i == '0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_pend_nxt    = cfg_div_i;
            w_pending_nxt = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_nxt = WAIT_FALL;
          w_t8_nxt    = '0;
        end
      end
      WAIT_FALL: begin
        if (w_fall) begin
          w_t8_nxt    = '0;
          w_ne_nxt    = '0;
          w_state_nxt = MEASURE;
        end else if (w_t8_inc == TIMEOUT_T8) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_t8_nxt = w_t8_inc;
        end
      end
      MEASURE: begin
        if (w_t8_inc == TIMEOUT_T8) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_t8_nxt = w_t8_inc;
          if (w_fall) begin
            w_ne_nxt = r_ne + 3'd1;
            if (r_ne == 3'd3) begin
              w_state_nxt = CALC;
            end
          end
        end
      end
      CALC: begin
        if (w_ab_div == '0) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_pend_nxt    = DIV_W'(w_ab_div);
          w_pending_nxt = 1'b1;
          w_state_nxt   = COMMIT;
        end
      end
      COMMIT: begin
        if (en_16x_baud_i) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign baud_config_o = r_baud;
  assign cfg_pending_o = r_pending;
  assign ab_busy_o     = r_busy;
  assign ab_done_o     = r_done;
  assign ab_err_o      = r_err;

endmodule

// File: tb/tb_baud_ctrl.sv
// Self-checking bench for baud_ctrl: manual staging, auto-baud, timeout, collisions, reset.
module tb_baud_ctrl;

  localparam logic [23:0] TO_T8 = 24'd14000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_i;
  logic        en_16x_baud_i;
  logic        cfg_wr_i;
  logic [15:0] cfg_div_i;
  logic        ab_start_i;
  logic [15:0] baud_config_o;
  logic        cfg_pending_o;
  logic        ab_busy_o;
  logic        ab_done_o;
  logic        ab_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  int          err_cyc  = 0;
  int          done_cyc = 0;
  int          both_cyc = 0;
  logic [15:0] done_baud = '0;
  logic        done_busy = 1'b0;

  logic tick_auto = 1'b0;
  logic tick_gen  = 1'b0;
  logic tick_man  = 1'b0;
  int   tick_cnt  = 0;

  assign en_16x_baud_i = tick_gen | tick_man;

  baud_ctrl #(
    .DEFAULT_DIV(16'd27),
    .SYNC_STAGES(2),
    .TIMEOUT_T8 (TO_T8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_i),
    .en_16x_baud_i(en_16x_baud_i),
    .cfg_wr_i     (cfg_wr_i),
    .cfg_div_i    (cfg_div_i),
    .ab_start_i   (ab_start_i),
    .baud_config_o(baud_config_o),
    .cfg_pending_o(cfg_pending_o),
    .ab_busy_o    (ab_busy_o),
    .ab_done_o    (ab_done_o),
    .ab_err_o     (ab_err_o)
  );

  always #5 clk = ~clk;

  // Free-running generator model: one tick every 27 cycles when enabled.
  always @(negedge clk) begin
    if (tick_auto) begin
      if (tick_cnt >= 26) begin
        tick_cnt = 0;
        tick_gen = 1'b1;
      end else begin
        tick_cnt = tick_cnt + 1;
        tick_gen = 1'b0;
      end
    end else begin
      tick_gen = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (ab_err_o) err_cyc = err_cyc + 1;
    if (ab_done_o) begin
      done_cyc  = done_cyc + 1;
      done_baud = baud_config_o;
      done_busy = ab_busy_o;
    end
    if (ab_err_o && ab_done_o) both_cyc = both_cyc + 1;
  end

  // Expected auto-baud divisor: bit time / 16, rounded to nearest.
  function automatic int ab_model(input int p);
    return (8 * p + 64) / 128;
  endfunction

  task automatic write_div(input logic [15:0] v);
    @(negedge clk);
    cfg_wr_i  = 1'b1;
    cfg_div_i = v;
    @(negedge clk);
    cfg_wr_i  = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    tick_man = 1'b1;
    @(negedge clk);
    tick_man = 1'b0;
  endtask

  task automatic start_ab();
    @(negedge clk);
    ab_start_i = 1'b1;
    @(negedge clk);
    ab_start_i = 1'b0;
  endtask

  task automatic send_55(input int p, input int nbits);
    logic [9:0] frame;
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx_i = frame[i];
      repeat (p) @(negedge clk);
    end
    rx_i = 1'b1;
  endtask

  task automatic wait_ab(input int d0, input int e0, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done_cyc != d0 || err_cyc != e0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_i = 1'b1; cfg_wr_i = 1'b0; cfg_div_i = '0; ab_start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (baud_config_o !== 16'd27) begin n_fail++; $display("FAIL reset_baud: got %0d want 27", baud_config_o); end
    n_tests++; if (cfg_pending_o !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", cfg_pending_o); end
    n_tests++; if (ab_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ab_busy_o); end
    n_tests++; if (ab_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ab_done_o); end
    n_tests++; if (ab_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", ab_err_o); end
  endtask

  task automatic test_manual();
    logic [15:0] v, b0;
    int e0, n;
    // Free-running ticks: write 100, must apply within one tick period.
    tick_auto = 1'b1;
    write_div(16'd100);
    n_tests++; if (cfg_pending_o !== 1'b1) begin n_fail++; $display("FAIL man_pending: got %b want 1", cfg_pending_o); end
    n = 0;
    while (cfg_pending_o === 1'b1 && n < 60) begin @(negedge clk); n++; end
    n_tests++; if (n > 28) begin n_fail++; $display("FAIL man_latency: got %0d cycles want <=28", n); end
    n_tests++; if (baud_config_o !== 16'd100) begin n_fail++; $display("FAIL man_apply: got %0d want 100", baud_config_o); end
    tick_auto = 1'b0;
    repeat (2) @(negedge clk);
    // Manual ticks: value must hold until the tick, then apply.
    for (int k = 0; k < 4; k++) begin
      v  = 16'($urandom_range(1, 65535));
      b0 = baud_config_o;
      write_div(v);
      repeat ($urandom_range(1, 10)) @(negedge clk);
      n_tests++; if (baud_config_o !== b0 || cfg_pending_o !== 1'b1) begin
        n_fail++; $display("FAIL man_hold: got %0d/%b want %0d/1", baud_config_o, cfg_pending_o, b0);
      end
      pulse_tick();
      n_tests++; if (baud_config_o !== v || cfg_pending_o !== 1'b0) begin
        n_fail++; $display("FAIL man_commit: got %0d/%b want %0d/0", baud_config_o, cfg_pending_o, v);
      end
    end
    // Zero write is rejected with a single error pulse.
    b0 = baud_config_o;
    e0 = err_cyc;
    write_div(16'd0);
    repeat (2) @(negedge clk);
    pulse_tick();
    n_tests++; if (err_cyc !== e0 + 1) begin n_fail++; $display("FAIL zero_err: got %0d pulses want 1", err_cyc - e0); end
    n_tests++; if (baud_config_o !== b0 || cfg_pending_o !== 1'b0) begin
      n_fail++; $display("FAIL zero_nochange: got %0d/%b want %0d/0", baud_config_o, cfg_pending_o, b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, c, d;
    a = 16'($urandom_range(1, 999)); b = a + 16'd1000;
    c = a + 16'd2000; d = a + 16'd3000;
    tick_auto = 1'b0;
    write_div(a);
    write_div(b);
    pulse_tick();
    n_tests++; if (baud_config_o !== b) begin n_fail++; $display("FAIL overwrite: got %0d want %0d", baud_config_o, b); end
    write_div(c);
    @(negedge clk);
    cfg_wr_i = 1'b1; cfg_div_i = d; tick_man = 1'b1;
    @(negedge clk);
    cfg_wr_i = 1'b0; tick_man = 1'b0;
    n_tests++; if (baud_config_o !== c || cfg_pending_o !== 1'b1) begin
      n_fail++; $display("FAIL tick_write_old: got %0d/%b want %0d/1", baud_config_o, cfg_pending_o, c);
    end
    pulse_tick();
    n_tests++; if (baud_config_o !== d || cfg_pending_o !== 1'b0) begin
      n_fail++; $display("FAIL tick_write_new: got %0d/%b want %0d/0", baud_config_o, cfg_pending_o, d);
    end
  endtask

  task automatic test_autobaud(input int p);
    int exp, d0, e0;
    logic [15:0] b0;
    exp = ab_model(p);
    b0  = baud_config_o;
    d0  = done_cyc;
    e0  = err_cyc;
    tick_auto = 1'b1;
    start_ab();
    n_tests++; if (ab_busy_o !== 1'b1) begin n_fail++; $display("FAIL ab_busy_p%0d: got %b want 1", p, ab_busy_o); end
    send_55(p, 10);
    wait_ab(d0, e0, 200);
    if (exp == 0) begin
      n_tests++; if (err_cyc !== e0 + 1 || done_cyc !== d0) begin
        n_fail++; $display("FAIL ab_zero_p%0d: got err %0d done %0d want err 1 done 0", p, err_cyc - e0, done_cyc - d0);
      end
      n_tests++; if (baud_config_o !== b0 || ab_busy_o !== 1'b0) begin
        n_fail++; $display("FAIL ab_zero_hold_p%0d: got %0d/%b want %0d/0", p, baud_config_o, ab_busy_o, b0);
      end
    end else begin
      n_tests++; if (done_cyc !== d0 + 1 || err_cyc !== e0) begin
        n_fail++; $display("FAIL ab_done_p%0d: got done %0d err %0d want done 1 err 0", p, done_cyc - d0, err_cyc - e0);
      end
      n_tests++; if (done_baud !== 16'(exp) || done_busy !== 1'b0) begin
        n_fail++; $display("FAIL ab_div_p%0d: got %0d/busy %b want %0d/busy 0", p, done_baud, done_busy, exp);
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] b0;
    int e0, d0, n;
    b0 = baud_config_o;
    e0 = err_cyc;
    d0 = done_cyc;
    tick_auto = 1'b1;
    rx_i = 1'b1;
    @(negedge clk);
    ab_start_i = 1'b1;
    n = 0;
    while (err_cyc == e0 && n < int'(TO_T8) + 200) begin
      @(negedge clk);
      ab_start_i = 1'b0;
      n++;
    end
    n_tests++; if (n < int'(TO_T8) || n > int'(TO_T8) + 4) begin
      n_fail++; $display("FAIL timeout_cycles: got %0d want %0d..%0d", n, TO_T8, TO_T8 + 4);
    end
    @(negedge clk);
    n_tests++; if (baud_config_o !== b0 || ab_busy_o !== 1'b0 || done_cyc !== d0) begin
      n_fail++; $display("FAIL timeout_state: got %0d/busy %b/done %0d want %0d/0/0", baud_config_o, ab_busy_o, done_cyc - d0, b0);
    end
  endtask

  task automatic test_collision();
    int d0, e0;
    tick_auto = 1'b1;
    d0 = done_cyc; e0 = err_cyc;
    start_ab();
    fork
      send_55(200, 10);
      begin
        repeat (5 * 200) @(negedge clk);
        cfg_wr_i = 1'b1; cfg_div_i = 16'd50;
        @(negedge clk);
        cfg_wr_i = 1'b0;
        n_tests++; if (cfg_pending_o !== 1'b0) begin n_fail++; $display("FAIL busy_wr_ignored: got %b want 0", cfg_pending_o); end
      end
    join
    wait_ab(d0, e0, 200);
    n_tests++; if (baud_config_o !== 16'(ab_model(200)) || err_cyc !== e0) begin
      n_fail++; $display("FAIL busy_wr_result: got %0d err %0d want %0d err 0", baud_config_o, err_cyc - e0, ab_model(200));
    end
    d0 = done_cyc; e0 = err_cyc;
    @(negedge clk);
    ab_start_i = 1'b1; cfg_wr_i = 1'b1; cfg_div_i = 16'd77;
    @(negedge clk);
    ab_start_i = 1'b0; cfg_wr_i = 1'b0;
    n_tests++; if (ab_busy_o !== 1'b1 || cfg_pending_o !== 1'b0) begin
      n_fail++; $display("FAIL start_wr: got busy %b pend %b want 1/0", ab_busy_o, cfg_pending_o);
    end
    send_55(300, 10);
    wait_ab(d0, e0, 200);
    n_tests++; if (baud_config_o !== 16'(ab_model(300))) begin
      n_fail++; $display("FAIL start_wr_result: got %0d want %0d", baud_config_o, ab_model(300));
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    // Reset while measuring.
    tick_auto = 1'b1;
    d0 = done_cyc;
    start_ab();
    send_55(300, 5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (baud_config_o !== 16'd27 || ab_busy_o !== 1'b0 || cfg_pending_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_measure: got %0d/busy %b/pend %b want 27/0/0", baud_config_o, ab_busy_o, cfg_pending_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick_auto = 1'b0;
    write_div(16'd5);
    pulse_tick();
    n_tests++; if (baud_config_o !== 16'd5 || done_cyc !== d0) begin
      n_fail++; $display("FAIL rst_measure_idle: got %0d done %0d want 5 done 0", baud_config_o, done_cyc - d0);
    end
    // Reset while waiting for the commit tick.
    start_ab();
    send_55(250, 10);
    repeat (10) @(negedge clk);
    n_tests++; if (ab_busy_o !== 1'b1 || cfg_pending_o !== 1'b1) begin
      n_fail++; $display("FAIL commit_wait: got busy %b pend %b want 1/1", ab_busy_o, cfg_pending_o);
    end
    rst = 1'b1;
    #1;
    n_tests++; if (baud_config_o !== 16'd27 || ab_busy_o !== 1'b0 || cfg_pending_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_commit: got %0d/busy %b/pend %b want 27/0/0", baud_config_o, ab_busy_o, cfg_pending_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulse_tick();
    pulse_tick();
    n_tests++; if (baud_config_o !== 16'd27 || done_cyc !== d0) begin
      n_fail++; $display("FAIL rst_commit_discard: got %0d done %0d want 27 done 0", baud_config_o, done_cyc - d0);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_back_to_back();
    test_autobaud(432);
    test_autobaud(1600);
    test_autobaud(4);
    test_autobaud(8);
    test_autobaud($urandom_range(10, 400));
    test_autobaud($urandom_range(10, 400));
    test_timeout();
    test_collision();
    test_reset_mid();
    n_tests++; if (both_cyc !== 0) begin n_fail++; $display("FAIL err_done_overlap: got %0d cycles want 0", both_cyc); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/baud_ctrl.md
# baud_ctrl

Controller that owns the 16-bit divisor feeding the UART 16x baud generator. It applies software-written divisors and auto-baud results only at the generator's wrap point (cycle with `en_16x_baud_i` high, generator counter at 0). This prevents a mid-count change from stranding the counter above the new terminal value. Auto-baud measures a received 0x55 character on the RX line and derives the divisor with no software arithmetic.

## Interface
Parameters:
- `DEFAULT_DIV`, 16'd27: divisor after reset (50 MHz, 115200 baud).
- `SYNC_STAGES`, 2: RX synchronizer depth (2 or 3).

Ports:
- `clk`  in  1: single clock domain.
- `rst`  in  1: reset; one clock; reset is asynchronous and active-high.
- `rx_i`  in  1: raw asynchronous UART RX line, idle high.
- `en_16x_baud_i`  in  1: 16x tick from the generator; high only in the cycle after its counter wraps.
- `cfg_wr_i`  in  1: one-cycle write strobe for a manual divisor.
- `cfg_div_i`  in  16: manual divisor, sampled when `cfg_wr_i` is high.
- `ab_start_i`  in  1: one-cycle request to run auto-baud.
- `baud_config_o`  out  16: divisor to the generator; reset `DEFAULT_DIV`.
- `cfg_pending_o`  out  1: a divisor is staged and waiting for a tick; reset 0.
- `ab_busy_o`  out  1: auto-baud in progress, from start accept through commit; reset 0.
- `ab_done_o`  out  1: one-cycle pulse when the auto-baud divisor is committed; reset 0.
- `ab_err_o`  out  1: one-cycle pulse on auto-baud timeout, zero result, or zero manual write; reset 0.

## Operation
- RX path: `SYNC_STAGES` flops with reset value 1, then a falling-edge detector (`fall` = previous 1, current 0).
- Staging: register `pend_div` with flag `cfg_pending_o`. On any tick with the flag set: `baud_config_o <= pend_div`, flag cleared.
- Manual write (`cfg_wr_i` while `ab_busy_o`=0):
  - nonzero value: load `pend_div`, set flag. A later write overwrites a still-pending value.
  - value 0: rejected; `ab_err_o` pulses; state unchanged.
- Tick and write in the same cycle: the old `pend_div` commits, the new value is staged, and the flag stays set.
- While `ab_busy_o`=1, `cfg_wr_i` is ignored silently and `ab_start_i` is ignored.
- `ab_start_i` and `cfg_wr_i` in the same idle cycle: auto-baud is accepted and the write is dropped.
- Auto-baud state machine:
  - IDLE: on `ab_start_i`, go to WAIT_HIGH.
  - WAIT_HIGH: wait until synchronized RX is 1, then go to WAIT_FALL. This prevents starting mid-character.
  - WAIT_FALL: on first `fall`, clear T8 and edge count `ne`, then go to MEASURE.
  - MEASURE: T8 increments every cycle and `ne` increments on each `fall`. On the 4th further fall, go to CALC. The falls fall at the start of bits 0, 2, 4, 6 and 8 of 0x55, so T8 spans 8 bit times.
  - CALC: `div = (T8 + 64) >> 7`, computed in 24 bits. If `div`=0, pulse `ab_err_o` and go to IDLE. Otherwise load `pend_div`, set the flag, and go to COMMIT.
  - COMMIT: wait for the tick that applies the value. That tick pulses `ab_done_o` and returns to IDLE.
- Timeout: in WAIT_FALL or MEASURE, if T8 reaches `MAX_T8` = 24'h7FFFC0, pulse `ab_err_o` and go to IDLE. This caps `div` at 65535. WAIT_FALL also uses the T8 counter as its timeout.
- On error, `baud_config_o` and `pend_div` are unchanged.
- Reset in any state: all outputs return to reset values immediately, the state machine goes to IDLE, and any staged divisor is discarded.

## Timing
- RX-to-edge latency is `SYNC_STAGES`+1 cycles. It is constant, so it cancels out of T8.
- Manual commit latency: `baud_config_o` updates in the cycle after the first tick following the write, or the next tick at or after it.
- CALC takes exactly 1 cycle. COMMIT lasts until the next tick: at most the old divisor in cycles.
- `ab_done_o` is asserted in the same cycle `baud_config_o` takes the new value. `ab_busy_o` falls in that cycle too.
- `ab_err_o` is a single-cycle pulse. It never coincides with `ab_done_o`.

## Structure
- Package `uart_pkg`: auto-baud state enum (IDLE, WAIT_HIGH, WAIT_FALL, MEASURE, CALC, COMMIT), `MAX_T8`, the T8 width of 24, and the rounding constant 64.
- Sub-module `baud_rx_sync`: synchronizer plus falling-edge detector. It outputs `rx_s` and `fall`.

## Test plan
- Reset: release reset → `baud_config_o`=27; `cfg_pending_o`, `ab_busy_o`, `ab_done_o`, `ab_err_o` all 0.
- Manual write: write 100 while the generator ticks every 27 cycles → `cfg_pending_o`=1 until the next tick, then `baud_config_o`=100. Write 0 → single `ab_err_o` pulse, no change.
- Auto-baud, 432 cycles per bit: 0x55 → T8=3456, `div`=(3456+64)>>7=27, `ab_done_o` at commit tick. Repeat at 1600 cycles per bit → `div`=100.
- Timeout: start auto-baud with RX held high → `ab_err_o` when T8 hits 24'h7FFFC0; divisor unchanged; `ab_busy_o` drops.
- Collisions: `cfg_wr_i`=50 during MEASURE → ignored, auto-baud result wins. `ab_start_i`+`cfg_wr_i` in the same idle cycle → auto-baud only. Tick coincident with a new write → old value commits, new value stays pending.
- Mid-operation reset: assert `rst` during MEASURE and again during COMMIT → IDLE, `baud_config_o`=27, no `ab_done_o`.
